seq_stim_ctrl: RTL and testbench
================================

Name: seq_stim_ctrl

Overview:
Stimulus sequencer and activity monitor for the serial sequence detector (x, clk, rst, z) in the power-estimation flow. On a start request it loads a pattern word and resets the detector. It then shifts the pattern into the detector's x input MSB-first and samples z. It reports match count plus x/z toggle counts, which feed switching-activity estimation.

Parameters:
PAT_W, 16, pattern width in bits (max sequence length)
LEN_W, 5, width of len input; must hold 0..PAT_W
CNT_W, 8, width of each result counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  run request; sampled only in IDLE
pattern  in  PAT_W  bit sequence, MSB presented first; latched on accepted start
len  in  LEN_W  number of bits to present; latched on accepted start; values >PAT_W clamp to PAT_W
det_x  out  1  registered serial stimulus to detector x
det_rst  out  1  registered detector reset pulse
det_z  in  1  detector output z
busy  out  1  high in CLR, SHIFT, DRAIN
done  out  1  one-cycle pulse in DONE
match_cnt  out  CNT_W  samples with det_z=1
x_toggle_cnt  out  CNT_W  transitions on det_x during the run
z_toggle_cnt  out  CNT_W  transitions across sampled det_z values

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; shift register, remaining-count and previous-x/z trackers cleared.
- FSM states: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: start=1 and len!=0 -> latch pattern/clamped len; clear all three counters; go CLR. start=1 and len==0 -> clear counters; go DONE directly; det_rst is never asserted. start=0 -> stay.
- CLR (1 cycle): det_rst=1, det_x=0; go SHIFT.
- SHIFT (len cycles): in the k-th SHIFT cycle (k=0..len-1), det_x=pattern bit [PAT_W-1-k]. det_x is registered and changes only at cycle boundaries. After the last bit, go DRAIN.
- DRAIN (1 cycle): det_x=0; final z sample taken; go DONE.
- DONE (1 cycle): done=1, busy=0; go IDLE. Counters hold their values until the next accepted start.
- Sampling: det_z is sampled in SHIFT cycles k=1..len-1 and in DRAIN, giving exactly len samples. Sample j reflects the detector's response to bit j (one-cycle latency).
- match_cnt: +1 per sample equal to 1.
- z_toggle_cnt: +1 per sample that differs from the previous sample. The first sample is compared against 0.
- x_toggle_cnt: +1 per presented bit that differs from the previous presented bit. The first bit is compared against 0 (det_x level in CLR).
- All counters saturate at 2^CNT_W-1; no wrap.
- start while not in IDLE is ignored; pattern and len are not re-latched.
- Latency: start accepted at edge N -> CLR in cycle N+1; SHIFT in cycles N+2..N+1+len; DRAIN in N+2+len; done in N+3+len.
- det_x=0 and det_rst=0 in IDLE, DRAIN and DONE.
- rst asserted mid-run aborts immediately. No done is produced and counters read 0. The next start after reset release runs normally.

Test Plan:
1. Assert rst with start=1 and det_z=1 -> all outputs 0; no state change until rst is released.
2. pattern=16'hA000, len=4, det_z tied 0 -> det_rst high for 1 cycle, then det_x=1,0,1,0; x_toggle_cnt=4, match_cnt=0, z_toggle_cnt=0; done 7 cycles after the start edge.
3. pattern=16'hFFFF, len=16, det_z tied 1 -> match_cnt=16, x_toggle_cnt=1, z_toggle_cnt=1; busy for 18 cycles; done at N+19.
4. len=0 -> no det_rst, det_x stays 0, done pulses in cycle N+1, all counters 0. Then len=20 with pattern=16'h0001 -> clamped to 16; x_toggle_cnt=1.
5. Pulse start mid-SHIFT -> ignored, counts unchanged vs. golden. Assert rst during SHIFT -> outputs 0 immediately. A new run after release gives the correct counts.
6. CNT_W=3, pattern=16'hAAAA, len=16, det_z stub alternating 1,0,1,... per sample -> match_cnt=7 and z_toggle_cnt=7 (saturated), x_toggle_cnt=7.

Source files
------------

// File: rtl/seq_stim_ctrl.sv
// Stimulus sequencer for a serial sequence detector: shifts a pattern into det_x
// MSB-first, samples det_z, and accumulates match and x/z toggle counts.
module seq_stim_ctrl #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] x_toggle_cnt,
  output logic [CNT_W-1:0] z_toggle_cnt
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             zprev_q, zprev_d;
  logic             det_x_q, det_x_d;
  logic             det_rst_q, det_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] xtog_q, xtog_d;
  logic [CNT_W-1:0] ztog_q, ztog_d;
  logic             sample;
  logic [LEN_W-1:0] len_clamped;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      zprev_q   <= 1'b0;
      det_x_q   <= 1'b0;
      det_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= '0;
      xtog_q    <= '0;
      ztog_q    <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      zprev_q   <= zprev_d;
      det_x_q   <= det_x_d;
      det_rst_q <= det_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
      xtog_q    <= xtog_d;
      ztog_q    <= ztog_d;
    end
  end

  // det_x_d is the level for the coming cycle; det_x_q is the bit currently presented.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    first_d = 1'b0;
    zprev_d = zprev_q;
    det_x_d = 1'b0;
    match_d = match_q;
    xtog_d  = xtog_q;
    ztog_d  = ztog_q;
    sample  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          match_d = '0;
          xtog_d  = '0;
          ztog_d  = '0;
          zprev_d = 1'b0;
          if (len != '0) begin
            sh_d    = pattern;
            rem_d   = len_clamped;
            state_d = CLR;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLR: begin
        det_x_d = sh_q[PAT_W-1];
        sh_d    = sh_q << 1;
        rem_d   = rem_q - 1'b1;
        first_d = 1'b1;
        if (sh_q[PAT_W-1] != det_x_q) xtog_d = sat_inc(xtog_q);
        state_d = SHIFT;
      end
      SHIFT: begin
        sample = !first_q;
        if (rem_q != '0) begin
          det_x_d = sh_q[PAT_W-1];
          sh_d    = sh_q << 1;
          rem_d   = rem_q - 1'b1;
          if (sh_q[PAT_W-1] != det_x_q) xtog_d = sat_inc(xtog_q);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        sample  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The first SHIFT cycle has no response yet; DRAIN catches the last bit's response.
    if (sample) begin
      if (det_z) match_d = sat_inc(match_q);
      if (det_z != zprev_q) ztog_d = sat_inc(ztog_q);
      zprev_d = det_z;
    end
  end

  assign det_rst_d = (state_d == CLR);
  assign busy_d    = (state_d == CLR) || (state_d == SHIFT) || (state_d == DRAIN);
  assign done_d    = (state_d == DONE);

  assign det_x        = det_x_q;
  assign det_rst      = det_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign match_cnt    = match_q;
  assign x_toggle_cnt = xtog_q;
  assign z_toggle_cnt = ztog_q;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Randomized scoreboard bench for seq_stim_ctrl; a second instance with 3-bit
// counters exercises saturation on the same stimulus.
module tb_seq_stim_ctrl;

   localparam int PAT_W = 16;
   localparam int LEN_W = 5;

   typedef struct {
      int m;
      int xt;
      int zt;
   } expT;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic             detZ;

   logic       detXA, detRstA, busyA, doneA;
   logic [7:0] matchA, xTogA, zTogA;
   logic       detXB, detRstB, busyB, doneB;
   logic [2:0] matchB, xTogB, zTogB;

   expT sbA[$];
   expT sbB[$];
   int  checks = 0;
   int  passes = 0;

   seq_stim_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(8)) dutA (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
      .det_x(detXA), .det_rst(detRstA), .det_z(detZ), .busy(busyA), .done(doneA),
      .match_cnt(matchA), .x_toggle_cnt(xTogA), .z_toggle_cnt(zTogA)
   );

   seq_stim_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(3)) dutB (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
      .det_x(detXB), .det_rst(detRstB), .det_z(detZ), .busy(busyB), .done(doneB),
      .match_cnt(matchB), .x_toggle_cnt(xTogB), .z_toggle_cnt(zTogB)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Single comparison point: every check steps the counts printed in the summary
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: walk the presented bits and sampled z values, count, then saturate
   function automatic expT model(input logic [PAT_W-1:0] p, input int n,
                                 input logic [PAT_W-1:0] zs, input int maxv);
      expT r;
      logic px, pz;
      r.m = 0; r.xt = 0; r.zt = 0;
      px = 1'b0; pz = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (p[PAT_W-1-k] != px) r.xt++;
         px = p[PAT_W-1-k];
         if (zs[k]) r.m++;
         if (zs[k] != pz) r.zt++;
         pz = zs[k];
      end
      if (r.m > maxv) r.m = maxv;
      if (r.xt > maxv) r.xt = maxv;
      if (r.zt > maxv) r.zt = maxv;
      return r;
   endfunction

   // Monitor: pops the oldest expectation whenever a DUT pulses done
   always @(negedge clk) begin
      expT e;
      if (!rst && doneA) begin
         checkOutput("doneA_expected", int'(sbA.size() > 0), 1);
         if (sbA.size() > 0) begin
            e = sbA.pop_front();
            checkOutput("matchA", int'(matchA), e.m);
            checkOutput("xTogA", int'(xTogA), e.xt);
            checkOutput("zTogA", int'(zTogA), e.zt);
         end
      end
      if (!rst && doneB) begin
         checkOutput("doneB_expected", int'(sbB.size() > 0), 1);
         if (sbB.size() > 0) begin
            e = sbB.pop_front();
            checkOutput("matchB_sat", int'(matchB), e.m);
            checkOutput("xTogB_sat", int'(xTogB), e.xt);
            checkOutput("zTogB_sat", int'(zTogB), e.zt);
         end
      end
   end

   // One run: accept at edge N, then step interval by interval (e = edges since N),
   // driving det_z from the sample plan and checking the serial outputs' timing.
   task automatic applyStimulus(input logic [PAT_W-1:0] pat, input int lenIn,
                                input logic [PAT_W-1:0] zs, input int abortAt,
                                input bit midStart);
      int  n;
      expT eA, eB;
      int  expX, expRst, expBusy, expDone;
      n  = (lenIn > PAT_W) ? PAT_W : lenIn;
      eA = model(pat, n, zs, 255);
      eB = model(pat, n, zs, 7);
      @(posedge clk); #1;
      start   = 1'b1;
      pattern = pat;
      len     = LEN_W'(lenIn);
      detZ    = 1'($urandom);
      sbA.push_back(eA);
      sbB.push_back(eB);
      @(posedge clk); #1;
      pattern = PAT_W'($urandom);
      len     = LEN_W'($urandom);
      for (int e = 0; e <= n + 3; e++) begin
         detZ  = (e >= 2 && e <= n + 1) ? zs[e-2] : 1'($urandom);
         start = (midStart && e == 2) ? 1'b1 : 1'b0;
         if (abortAt >= 0 && e == abortAt) begin
            rst = 1'b1;
            #1;
            checkOutput("abort_detX", int'(detXA), 0);
            checkOutput("abort_detRst", int'(detRstA), 0);
            checkOutput("abort_busy", int'(busyA), 0);
            checkOutput("abort_done", int'(doneA), 0);
            checkOutput("abort_match", int'(matchA), 0);
            checkOutput("abort_xTog", int'(xTogA), 0);
            checkOutput("abort_zTogB", int'(zTogB), 0);
            void'(sbA.pop_back());
            void'(sbB.pop_back());
            start = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (n == 0) begin
            expRst = 0; expX = 0; expBusy = 0;
            expDone = (e == 0) ? 1 : 0;
         end else begin
            expRst  = (e == 0) ? 1 : 0;
            expX    = (e >= 1 && e <= n) ? int'(pat[PAT_W-e]) : 0;
            expBusy = (e <= n + 1) ? 1 : 0;
            expDone = (e == n + 2) ? 1 : 0;
         end
         @(negedge clk);
         checkOutput("detRst", int'(detRstA), expRst);
         checkOutput("detX", int'(detXA), expX);
         checkOutput("detXB", int'(detXB), expX);
         checkOutput("busy", int'(busyA), expBusy);
         checkOutput("done", int'(doneA), expDone);
         if (e == n + 3) begin
            checkOutput("hold_match", int'(matchA), eA.m);
            checkOutput("hold_xTog", int'(xTogA), eA.xt);
            checkOutput("hold_zTog", int'(zTogA), eA.zt);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   // Watchdog so the bench always ends even if the DUT wedges
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ln;
      int ab;
      rst     = 1'b1;
      start   = 1'b1;
      detZ    = 1'b1;
      pattern = 16'hFFFF;
      len     = 5'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_detX", int'(detXA), 0);
         checkOutput("rst_detRst", int'(detRstA), 0);
         checkOutput("rst_busy", int'(busyA), 0);
         checkOutput("rst_done", int'(doneA), 0);
         checkOutput("rst_match", int'(matchA), 0);
         checkOutput("rst_xTog", int'(xTogA), 0);
         checkOutput("rst_zTog", int'(zTogA), 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;

      applyStimulus(16'hA000, 4, 16'h0000, -1, 1'b0);
      applyStimulus(16'hFFFF, 16, 16'hFFFF, -1, 1'b0);
      applyStimulus(16'h1234, 0, 16'h0000, -1, 1'b0);
      applyStimulus(16'h0001, 20, 16'(($urandom)), -1, 1'b0);
      applyStimulus(16'hC3A5, 10, 16'h02F1, -1, 1'b1);
      applyStimulus(16'h9E37, 12, 16'h0FFF, 5, 1'b0);
      applyStimulus(16'h9E37, 12, 16'h0A5C, -1, 1'b0);
      applyStimulus(16'hAAAA, 16, 16'h5555, -1, 1'b0);

      for (int r = 0; r < 40; r++) begin
         ln = $urandom_range(0, 20);
         ab = (ln >= 2 && $urandom_range(0, 7) == 0) ? $urandom_range(1, (ln > 16 ? 16 : ln)) : -1;
         applyStimulus(16'($urandom), ln, 16'($urandom), ab, (ln >= 3) ? 1'($urandom) : 1'b0);
      end

      repeat (4) @(posedge clk);
      #1;
      checkOutput("sb_drained", int'(sbA.size() + sbB.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
